// File: rtl/regfile_dump_tx.sv
// rtl/regfile_dump_tx.sv - framed byte-stream dump of the PC and the register file
//
// On a start pulse the PC is captured and all NUM_REGS register-file entries
// are read through a spare asynchronous read port. They are sent as
// HDR_BYTE, PC[31:0], reg0..reg(NUM_REGS-1), each word MSB first.
// Compile-time option REGDUMP_CHECKSUM_EN appends an XOR checksum byte
// covering every byte after the header.
//
// Ports:
//   clk        in   core clock, rising-edge
//   rst        in   asynchronous active-high reset
//   start      in   request a dump (sampled in IDLE only)
//   pc_in      in   [31:0] current PC
//   rf_rd_addr out  [4:0]  register-file read address
//   rf_rd_data in   [31:0] register-file read data (combinational)
//   tx_data    out  [7:0]  byte offered to the sink
//   tx_valid   out  tx_data valid
//   tx_ready   in   sink accepts; transfer = tx_valid & tx_ready
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last byte transfers

module regfile_dump_tx #(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PC   = 3'd2,
    S_REG  = 3'd3,
`ifdef REGDUMP_CHECKSUM_EN
    S_CSUM = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q;
  logic [1:0]       byte_cnt;
  logic [RIW-1:0]   reg_idx;
  logic [7:0]       word_byte;
  logic             xfer;
  logic             word_end;
  logic             last_reg;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign xfer     = tx_valid & tx_ready;
  assign word_end = (byte_cnt == 2'd3);
  assign last_reg = (reg_idx == RIW'(NUM_REGS - 1));

  // Byte of the current word, MSB first.
  always_comb begin
    word_byte = word_q[31:24];
    case (byte_cnt)
      2'd0:    word_byte = word_q[31:24];
      2'd1:    word_byte = word_q[23:16];
      2'd2:    word_byte = word_q[15:8];
      default: word_byte = word_q[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR:  if (xfer) state_d = S_PC;
      S_PC:   if (xfer && word_end) state_d = S_REG;
      S_REG:  if (xfer && word_end && last_reg)
`ifdef REGDUMP_CHECKSUM_EN
                state_d = S_CSUM;
      S_CSUM: if (xfer) state_d = S_DONE;
`else
                state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they cannot change during a stall.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        busy     = 1'b1;
      end
      S_PC, S_REG: begin
        tx_valid = 1'b1;
        tx_data  = word_byte;
        busy     = 1'b1;
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        busy     = 1'b1;
      end
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. rf_rd_addr always points one word ahead of what is being sent,
  // so the next word can be loaded whole on the last byte of the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      byte_cnt   <= '0;
      reg_idx    <= '0;
      rf_rd_addr <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          rf_rd_addr <= '0;
          if (start) begin
            word_q   <= pc_in;
            byte_cnt <= '0;
            reg_idx  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        S_PC, S_REG: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q   <= csum_q ^ word_byte;
`endif
            if (word_end) begin
              word_q     <= rf_rd_data;
              rf_rd_addr <= rf_rd_addr + 5'd1;
              if (state_q == S_REG) reg_idx <= reg_idx + RIW'(1);
            end
          end
        end
        S_DONE: rf_rd_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule
